// File: rtl/astro_game_ctrl_pkg.sv
// Shared encodings and widths for the astro game-flow controller and its helpers.
package astro_game_ctrl_pkg;

   typedef enum logic [1:0] {
      QI      = 2'b00,
      QGAME_1 = 2'b01,
      QGAME_2 = 2'b10,
      QDONE   = 2'b11
   } state_e;

   localparam int SHOT_W = 4;
   localparam int TGT_W  = 3;
   localparam int BCD_W  = 4;

endpackage

// File: rtl/astro_game_ctrl_bcd_counter2.sv
// Two-digit BCD incrementer that saturates at 99, with a synchronous clear.
// Kept generic so it can also back a high-score register.
module astro_game_ctrl_bcd_counter2
   import astro_game_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [BCD_W-1:0] tens_o,
   output logic [BCD_W-1:0] ones_o
);

   logic [BCD_W-1:0] tens_q, tens_d;
   logic [BCD_W-1:0] ones_q, ones_d;
   logic             at_max;

   assign at_max = (tens_q == BCD_W'(9)) && (ones_q == BCD_W'(9));

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr_i) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc_i && !at_max) begin
         if (ones_q == BCD_W'(9)) begin
            ones_d = '0;
            tens_d = tens_q + BCD_W'(1);
         end else begin
            ones_d = ones_q + BCD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o = tens_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/astro_game_ctrl.sv
// Game-flow controller: start edge detect, level FSM, shot budget, targets and score.
// Every output is a register; effects show up the cycle after the triggering input.
module astro_game_ctrl
   import astro_game_ctrl_pkg::*;
#(
   parameter int SHOTS_L1   = 8,
   parameter int SHOTS_L2   = 6,
   parameter int TARGETS_L1 = 1,
   parameter int TARGETS_L2 = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              shot_fired,
   input  logic              hit,
   input  logic              bullet_done,
   output logic [1:0]        state,
   output logic              shoot_en,
   output logic              level_load,
   output logic [SHOT_W-1:0] shots_left,
   output logic [TGT_W-1:0]  targets_left,
   output logic [BCD_W-1:0]  score_tens,
   output logic [BCD_W-1:0]  score_ones,
   output logic              won
);

   state_e            state_q, state_d;
   logic              start_q;
   logic [SHOT_W-1:0] shots_q, shots_d;
   logic [TGT_W-1:0]  tgt_q, tgt_d;
   logic              won_q, won_d;
   logic              load_q, load_d;
   logic              en_q, en_d;
   logic              score_clr, score_inc;
   logic              start_rise, clear;

   assign start_rise = start & ~start_q;
   assign clear      = hit && (tgt_q == TGT_W'(1));

   always_comb begin
      state_d   = state_q;
      shots_d   = shots_q;
      tgt_d     = tgt_q;
      won_d     = won_q;
      load_d    = 1'b0;
      score_clr = 1'b0;
      score_inc = 1'b0;
      unique case (state_q)
         QI: begin
            if (start_rise) begin
               state_d   = QGAME_1;
               shots_d   = SHOT_W'(SHOTS_L1);
               tgt_d     = TGT_W'(TARGETS_L1);
               won_d     = 1'b0;
               load_d    = 1'b1;
               score_clr = 1'b1;
            end
         end
         QGAME_1, QGAME_2: begin
            if (shot_fired && shots_q != '0) shots_d = shots_q - SHOT_W'(1);
            if (hit) begin
               score_inc = 1'b1;
               if (tgt_q != '0) tgt_d = tgt_q - TGT_W'(1);
            end
            // A clearing hit outranks a loss; loss uses the pre-decrement budget.
            if (clear) begin
               if (state_q == QGAME_1) begin
                  state_d = QGAME_2;
                  shots_d = SHOT_W'(SHOTS_L2);
                  tgt_d   = TGT_W'(TARGETS_L2);
                  load_d  = 1'b1;
               end else begin
                  state_d = QDONE;
                  won_d   = 1'b1;
               end
            end else if (bullet_done && shots_q == '0) begin
               state_d = QDONE;
               won_d   = 1'b0;
            end
         end
         QDONE: begin
            if (!start) state_d = QI;
         end
         default: state_d = QI;
      endcase
      en_d = ((state_d == QGAME_1) || (state_d == QGAME_2)) && (shots_d != '0);
   end

   always_ff @(posedge clk) begin
      start_q <= start;
      if (reset) begin
         state_q <= QI;
         shots_q <= '0;
         tgt_q   <= '0;
         won_q   <= 1'b0;
         load_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shots_q <= shots_d;
         tgt_q   <= tgt_d;
         won_q   <= won_d;
         load_q  <= load_d;
         en_q    <= en_d;
      end
   end

   astro_game_ctrl_bcd_counter2 u_score (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (score_clr),
      .inc_i   (score_inc),
      .tens_o  (score_tens),
      .ones_o  (score_ones)
   );

   assign state        = state_q;
   assign shoot_en     = en_q;
   assign level_load   = load_q;
   assign shots_left   = shots_q;
   assign targets_left = tgt_q;
   assign won          = won_q;

endmodule
